// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the MAC datapath: field widths, exponent limits,
// the accumulator FSM state encoding and the packed FP16 field layout.
package fp16_pkg;

  localparam int FP16_W         = 16;
  localparam int EXP_W          = 5;
  localparam int MAN_W          = 10;
  localparam int EXP_BIAS       = 15;
  localparam int EXP_MAX_FINITE = 30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero count of the 12-bit significand sum; an all-zero input returns 12.
module fp16_lzc (
  input  logic [11:0] i_val,
  output logic [3:0]  o_lzc
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_lzc = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (i_val[i]) o_lzc = 4'(11 - i);
    end
  end

endmodule

// File: rtl/fp16_acc.sv
// Sequential FP16 accumulator (flush-to-zero, truncating) with group output handshake.
// Build option: define FP16_ACC_SAT_EN to clamp exponent overflow to the max finite value.
module fp16_acc
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CNT_W-1:0]  out_count
);

  state_t             r_state;
  fp16_t              r_acc;
  fp16_t              r_opnd;
  logic               r_last;
  logic [CNT_W-1:0]   r_count;
  logic [MAN_W:0]     r_big_sig;
  logic [MAN_W:0]     r_small_sig;
  logic [EXP_W-1:0]   r_big_exp;
  logic               r_big_sign;
  logic               r_small_sign;
  logic [MAN_W+1:0]   r_sum;
  logic               r_res_sign;

  logic [MAN_W:0]     w_acc_sig;
  logic [MAN_W:0]     w_opnd_sig;
  logic               w_opnd_bigger;
  logic [EXP_W-1:0]   w_exp_diff;
  logic [MAN_W:0]     w_small_sig;
  logic [MAN_W:0]     w_small_shifted;
  logic [MAN_W+1:0]   w_sum;
  logic               w_sum_sign;
  logic [3:0]         w_lzc;
  logic [MAN_W+1:0]   w_norm_sig;
  logic signed [6:0]  w_exp_norm;
  fp16_t              w_norm_res;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = (r_state == ST_OUT) ? r_acc : 16'h0000;
  assign out_count = (r_state == ST_OUT) ? r_count : '0;

  // exp==0 is treated as zero regardless of mantissa.
  assign w_acc_sig       = (r_acc.exp  != '0) ? {1'b1, r_acc.man}  : '0;
  assign w_opnd_sig      = (r_opnd.exp != '0) ? {1'b1, r_opnd.man} : '0;
  assign w_opnd_bigger   = (r_opnd.exp > r_acc.exp);
  assign w_exp_diff      = w_opnd_bigger ? (r_opnd.exp - r_acc.exp) : (r_acc.exp - r_opnd.exp);
  assign w_small_sig     = w_opnd_bigger ? w_acc_sig : w_opnd_sig;
  assign w_small_shifted = (w_exp_diff >= 5'd12) ? '0 : (w_small_sig >> w_exp_diff);

  always_comb begin
    w_sum      = '0;
    w_sum_sign = 1'b0;
    if (r_big_sign == r_small_sign) begin
      w_sum      = {1'b0, r_big_sig} + {1'b0, r_small_sig};
      w_sum_sign = r_big_sign;
    end else if (r_big_sig >= r_small_sig) begin
      w_sum      = {1'b0, r_big_sig - r_small_sig};
      w_sum_sign = r_big_sign;
    end else begin
      w_sum      = {1'b0, r_small_sig - r_big_sig};
      w_sum_sign = r_small_sign;
    end
  end

  fp16_lzc u_lzc (
    .i_val (r_sum),
    .o_lzc (w_lzc)
  );

  // Leading one lands on bit 11; a carry (lzc=0) yields the shift-right/exp+1 case.
  assign w_norm_sig = r_sum << w_lzc;
  assign w_exp_norm = $signed({2'b00, r_big_exp}) + 7'sd1 - $signed({3'b000, w_lzc});

  always_comb begin
    w_norm_res = '0;
    if (r_sum == '0 || w_exp_norm <= 7'sd0) begin
      w_norm_res = '0;
    end else if (w_exp_norm > $signed(7'(EXP_MAX_FINITE))) begin
`ifdef FP16_ACC_SAT_EN
      w_norm_res = '{sign: r_res_sign, exp: 5'(EXP_MAX_FINITE), man: '1};
`else
      w_norm_res = '{sign: r_res_sign, exp: w_exp_norm[4:0], man: w_norm_sig[10:1]};
`endif
    end else begin
      w_norm_res = '{sign: r_res_sign, exp: w_exp_norm[4:0], man: w_norm_sig[10:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_opnd       <= '0;
      r_last       <= 1'b0;
      r_count      <= '0;
      r_big_sig    <= '0;
      r_small_sig  <= '0;
      r_big_exp    <= '0;
      r_big_sign   <= 1'b0;
      r_small_sign <= 1'b0;
      r_sum        <= '0;
      r_res_sign   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_opnd  <= in_data;
          r_last  <= in_last;
          if (r_count != '1) r_count <= r_count + 1'b1;
          r_state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          r_big_sig    <= w_opnd_bigger ? w_opnd_sig : w_acc_sig;
          r_small_sig  <= w_small_shifted;
          r_big_exp    <= w_opnd_bigger ? r_opnd.exp : r_acc.exp;
          r_big_sign   <= w_opnd_bigger ? r_opnd.sign : r_acc.sign;
          r_small_sign <= w_opnd_bigger ? r_acc.sign : r_opnd.sign;
          r_state      <= ST_ADD;
        end
        ST_ADD: begin
          r_sum      <= w_sum;
          r_res_sign <= w_sum_sign;
          r_state    <= ST_NORM;
        end
        ST_NORM: begin
          r_acc   <= w_norm_res;
          r_state <= r_last ? ST_OUT : ST_IDLE;
        end
        ST_OUT: if (out_ready) begin
          r_acc   <= '0;
          r_count <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_acc.sv
// Directed self-checking bench for fp16_acc with hand-computed FP16 sums.
module tb_fp16_acc;

  localparam int CNT_W = 8;
`ifdef FP16_ACC_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h7BFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0000;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  fp16_acc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_d, input int exp_c);
    wait_out();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, cyc - acc_cyc, 3);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_count"}, out_count, exp_c);
    $display("group %s: out_data=%h out_count=%0d", tag, out_data, out_count);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_count", out_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1 + 1 = 2
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    get_result("basic", 16'h4000, 2);

    // 1 + 1 + 1 = 3
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    get_result("three", 16'h4200, 3);

    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b1);
    get_result("cancel", 16'h0000, 2);

    send(16'h0001, 1'b1);
    get_result("flush", 16'h0000, 1);

    // 2 + (-1) = 1, exercises left normalisation
    send(16'h4000, 1'b0);
    send(16'hBC00, 1'b1);
    get_result("sub_pos", 16'h3C00, 2);

    // -2 + 1 = -1
    send(16'hC000, 1'b0);
    send(16'h3C00, 1'b1);
    get_result("sub_neg", 16'hBC00, 2);

    send(16'h6400, 1'b0);
    send(16'h1400, 1'b1);
    get_result("align_loss", 16'h6400, 2);

    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    get_result("overflow", OVF_EXP, 2);

    // Backpressure: 2 + 2 = 4 held while in_valid is asserted
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b1);
    wait_out();
    chk("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 16'h3C00;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_data_hold", out_data, 16'h4400);
      chk("bp_count_hold", out_count, 2);
      chk("bp_in_ready", in_ready, 0);
    end
    $display("group backpressure: out_data=%h out_count=%0d", out_data, out_count);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_released", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    send(16'h3C00, 1'b1);
    get_result("after_bp", 16'h3C00, 1);

    // Reset asserted while the first product is in ADD
    send(16'h4000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 16'h0000);
    chk("midrst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h3C00, 1'b1);
    get_result("after_rst", 16'h3C00, 1);

    // 256 products saturate the 8-bit count at 255
    for (int i = 0; i < 256; i++) send(16'h0000, (i == 255));
    get_result("count_sat", 16'h0000, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
